// File: rtl/unidade_controle_vidas.sv
// Genius control unit: owns the game FSM plus the address, sequence, timer and lives counters.
// Build option: define CORINGA_EN so that tem_coringa counts as a correct entry while in ESPERA.
`timescale 1ns/1ps
module unidade_controle_vidas #(
    parameter int ADDR_W    = 4,
    parameter int T_ON      = 1000,
    parameter int T_OFF     = 500,
    parameter int T_TIMEOUT = 5000,
    parameter int VIDAS     = 3,
    parameter int LIFE_W    = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              nivel,
    input  logic              memoria,
    input  logic              tem_jogada,
    input  logic              jogadaIgualMemoria,
    input  logic              tem_coringa,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] sequencia,
    output logic              zeraR,
    output logic              registraR,
    output logic              led_ativo,
    output logic              estado_espera,
    output logic              macro_exibicao,
    output logic              macro_jogadas,
    output logic [LIFE_W-1:0] vidas,
    output logic              acertou,
    output logic              errou,
    output logic              pronto,
    output logic [3:0]        db_estado
);

    localparam int T_MAX = (T_TIMEOUT > T_ON)
                         ? ((T_TIMEOUT > T_OFF) ? T_TIMEOUT : T_OFF)
                         : ((T_ON > T_OFF) ? T_ON : T_OFF);
    localparam int TIMER_W = $clog2(T_MAX + 1);

    localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(T_ON - 1);
    localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(T_OFF - 1);
    localparam logic [TIMER_W-1:0] TO_LAST  = TIMER_W'(T_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  LAST_FULL = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0]  LAST_HALF = ADDR_W'((1 << (ADDR_W - 1)) - 1);

    typedef enum logic [3:0] {
        INICIAL     = 4'h0,
        PREPARACAO  = 4'h1,
        INICIA_SEQ  = 4'h2,
        ESPERA      = 4'h3,
        REGISTRA    = 4'h4,
        COMPARA     = 4'h5,
        PROXIMO     = 4'h6,
        ULTIMA_SEQ  = 4'h7,
        PROX_SEQ    = 4'h8,
        LEDS_ON     = 4'h9,
        FIM_ACERTO  = 4'hA,
        LEDS_OFF    = 4'hB,
        PERDE_VIDA  = 4'hC,
        PROXIMO_LED = 4'hD,
        FIM_ERRO    = 4'hE,
        INVALIDO    = 4'hF
    } state_t;

    state_t             state, state_next;
    logic [TIMER_W-1:0] timer;
    logic               nivel_r, memoria_r;
    logic               miss, abort, last_pos, timed;
    logic [ADDR_W-1:0]  last_idx;

`ifndef CORINGA_EN
    logic unused_coringa;
    assign unused_coringa = tem_coringa;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= INICIAL;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        miss       = 1'b0;
        abort      = 1'b0;
        last_pos   = (endereco == sequencia);
        last_idx   = nivel_r ? LAST_FULL : LAST_HALF;
        case (state)
            INICIAL:     if (iniciar) state_next = PREPARACAO;
            PREPARACAO:  state_next = LEDS_ON;
            INICIA_SEQ:  state_next = LEDS_ON;
            LEDS_ON:     if (timer == ON_LAST) state_next = LEDS_OFF;
            LEDS_OFF:    if (timer == OFF_LAST) state_next = last_pos ? ESPERA : PROXIMO_LED;
            PROXIMO_LED: state_next = LEDS_ON;
            ESPERA: begin
                if (timer == TO_LAST) miss = 1'b1;
`ifdef CORINGA_EN
                else if (tem_coringa) state_next = last_pos ? ULTIMA_SEQ : PROXIMO;
`endif
                else if (tem_jogada) state_next = REGISTRA;
            end
            REGISTRA:    state_next = COMPARA;
            COMPARA: begin
                if (!jogadaIgualMemoria) miss = 1'b1;
                else state_next = last_pos ? ULTIMA_SEQ : PROXIMO;
            end
            PROXIMO:     state_next = ESPERA;
            ULTIMA_SEQ:  state_next = (sequencia == last_idx) ? FIM_ACERTO : PROX_SEQ;
            PROX_SEQ:    state_next = INICIA_SEQ;
            PERDE_VIDA:  state_next = INICIA_SEQ;
            FIM_ACERTO:  if (iniciar) state_next = PREPARACAO;
            FIM_ERRO:    if (iniciar) state_next = PREPARACAO;
            default:     state_next = INICIAL;
        endcase
        if (miss) state_next = (vidas > LIFE_W'(1)) ? PERDE_VIDA : FIM_ERRO;
        // A change of level or memory bank mid-game ends it without touching the lives.
        if (!(state inside {INICIAL, FIM_ACERTO, FIM_ERRO, INVALIDO}) &&
            ((nivel != nivel_r) || (memoria != memoria_r))) begin
            abort      = 1'b1;
            state_next = FIM_ERRO;
        end
    end

    assign timed = (state inside {LEDS_ON, LEDS_OFF, ESPERA});

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco  <= '0;
            sequencia <= '0;
            vidas     <= LIFE_W'(VIDAS);
            timer     <= '0;
            nivel_r   <= 1'b0;
            memoria_r <= 1'b0;
        end else begin
            timer <= (timed && (state_next == state)) ? timer + 1'b1 : '0;
            // Configuration is captured on the way into PREPARACAO so the abort check sees it there.
            if (state_next == PREPARACAO) begin
                nivel_r   <= nivel;
                memoria_r <= memoria;
            end
            if (!abort) begin
                case (state)
                    PREPARACAO: begin
                        endereco  <= '0;
                        sequencia <= '0;
                        vidas     <= LIFE_W'(VIDAS);
                    end
                    INICIA_SEQ:           endereco  <= '0;
                    LEDS_OFF:             if (state_next == ESPERA) endereco <= '0;
                    PROXIMO_LED, PROXIMO: endereco  <= endereco + 1'b1;
                    PROX_SEQ:             sequencia <= sequencia + 1'b1;
                    PERDE_VIDA:           vidas     <= vidas - 1'b1;
                    default: ;
                endcase
                if (miss && (state_next == FIM_ERRO)) vidas <= '0;
            end
        end
    end

    always_comb begin
        zeraR          = (state == INICIAL) || (state == PREPARACAO);
        registraR      = (state == REGISTRA);
        led_ativo      = (state == LEDS_ON);
        estado_espera  = (state == ESPERA);
        macro_exibicao = (state inside {LEDS_ON, LEDS_OFF, PROXIMO_LED});
        macro_jogadas  = (state inside {ESPERA, REGISTRA, COMPARA, PROXIMO, ULTIMA_SEQ, PROX_SEQ});
        acertou        = (state == FIM_ACERTO);
        errou          = (state == FIM_ERRO);
        pronto         = (state == FIM_ACERTO) || (state == FIM_ERRO);
        db_estado      = state;
    end

endmodule

// File: doc/unidade_controle_vidas.md
Name: unidade_controle_vidas

Overview:
Parametrised control unit for the Genius memory game. It owns the FSM and the counters that the previous datapath kept outside:
- address counter, sequence counter, LED on/off timer, response timeout timer, lives counter.
- Adds a lives/retry mechanism: on a miss, the current sequence is replayed instead of ending the game.
- Drives the game datapath (memory address, jogada register) and the LED/display logic.

Parameters:
ADDR_W, 4, width of address/sequence counters; memory depth 2**ADDR_W
T_ON, 1000, cycles a LED stays lit during display
T_OFF, 500, cycles between LEDs during display
T_TIMEOUT, 5000, cycles allowed in ESPERA before a miss
VIDAS, 3, lives per game (>=1)
LIFE_W, 2, width of vidas output (2**LIFE_W > VIDAS)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
iniciar  in  1  start/restart game
nivel  in  1  0 = half game (last index 2**(ADDR_W-1)-1), 1 = full game (last index 2**ADDR_W-1)
memoria  in  1  memory-bank select; only monitored here
tem_jogada  in  1  one-cycle pulse, player pressed a button
jogadaIgualMemoria  in  1  registered jogada equals memory word at endereco
tem_coringa  in  1  one-cycle pulse, wildcard pressed
endereco  out  ADDR_W  memory address counter
sequencia  out  ADDR_W  index of last element of current round
zeraR  out  1  clear jogada register
registraR  out  1  load jogada register
led_ativo  out  1  display memory word on LEDs
estado_espera  out  1  in ESPERA
macro_exibicao  out  1  display phase
macro_jogadas  out  1  play phase
vidas  out  LIFE_W  remaining lives
acertou  out  1  final win
errou  out  1  final loss
pronto  out  1  game over (win or loss)
db_estado  out  4  state code

Behaviour:
- Reset (reset=0, async): state INICIAL; endereco=0, sequencia=0, timer=0, vidas=VIDAS. All outputs 0 except zeraR=1; db_estado=0.
- Outputs are Moore, decoded from state. Counters are registered.
- States (db_estado), transitions and counter actions:
  - INICIAL(0): zeraR. iniciar -> PREPARACAO.
  - PREPARACAO(1): zeraR; endereco=0, sequencia=0, vidas=VIDAS; latch nivel_r, memoria_r. -> LEDS_ON.
  - INICIA_SEQ(2): endereco=0. -> LEDS_ON.
  - LEDS_ON(9): led_ativo; timer counts. Exactly T_ON cycles, then -> LEDS_OFF with timer=0.
  - LEDS_OFF(B): exactly T_OFF cycles.
    - At end: if endereco==sequencia, set endereco=0 and go -> ESPERA.
    - Otherwise -> PROXIMO_LED.
  - PROXIMO_LED(D): endereco+1. -> LEDS_ON.
  - ESPERA(3): estado_espera; timer counts. Priority order:
    1. timer reaches T_TIMEOUT-1 -> miss.
    2. tem_coringa -> treated as a correct entry: endereco==sequencia ? ULTIMA_SEQ : PROXIMO.
    3. tem_jogada -> REGISTRA.
  - REGISTRA(4): registraR for 1 cycle. -> COMPARA.
  - COMPARA(5):
    - !jogadaIgualMemoria -> miss.
    - else endereco==sequencia -> ULTIMA_SEQ.
    - else -> PROXIMO.
  - PROXIMO(6): endereco+1, timer=0. -> ESPERA.
  - ULTIMA_SEQ(7): sequencia==last index (per nivel_r) -> FIM_ACERTO, else -> PROX_SEQ.
  - PROX_SEQ(8): sequencia+1. -> INICIA_SEQ.
  - PERDE_VIDA(C): vidas-1. -> INICIA_SEQ (same sequencia replayed).
  - FIM_ACERTO(A): acertou, pronto. iniciar -> PREPARACAO.
  - FIM_ERRO(E): errou, pronto. iniciar -> PREPARACAO.
- Miss handling: vidas>1 -> PERDE_VIDA; vidas==1 -> FIM_ERRO with vidas=0.
- Config abort: in any state except INICIAL/FIM_*, if nivel!=nivel_r or memoria!=memoria_r, go -> FIM_ERRO next cycle. This overrides all other transitions. Lives are not consumed.
- timer clears on every state change.
- macro_exibicao = LEDS_ON|LEDS_OFF|PROXIMO_LED.
- macro_jogadas = ESPERA|REGISTRA|COMPARA|PROXIMO|ULTIMA_SEQ|PROX_SEQ.
- Latency: tem_jogada in ESPERA -> registraR next cycle -> compare decision one cycle later.
- Simultaneous events:
  - tem_jogada with timeout: timeout wins.
  - iniciar mid-game: ignored.
- Unused code F: recover to INICIAL.

Optional Feature:
CORINGA_EN
- Defined: tem_coringa handled in ESPERA as described.
- Undefined: tem_coringa is ignored; ESPERA responds only to timeout and tem_jogada.

Test Plan:
- Reset low mid-LEDS_ON -> immediately db_estado=0, endereco=0, vidas=3, zeraR=1.
- iniciar, nivel=0, all jogadas correct -> display 1,2,...,8 LEDs per round (each T_ON on, T_OFF off). After round 8 -> FIM_ACERTO: acertou=1, pronto=1, db_estado=A.
- Wrong jogada in round 3 -> PERDE_VIDA, vidas=2. Round-3 sequence replayed with sequencia=2 unchanged.
- Three misses (timeout, wrong, timeout) -> vidas 2,1,0 -> FIM_ERRO on the third: errou=1, db_estado=E.
- Toggle nivel during ESPERA -> FIM_ERRO next cycle, vidas unchanged.
- CORINGA_EN: tem_coringa at endereco==sequencia=0 -> ULTIMA_SEQ, registraR never asserted. Without the macro, the same stimulus stays in ESPERA.
